// File: rtl/ysyx_23060191_trap_seq_pkg.sv
// Shared constants for the trap/return sequencer:
// CSR addresses, mstatus bit positions and sequencer states.
package ysyx_23060191_trap_seq_pkg;

    localparam logic [11:0] CSR_MTVEC   = 12'h305;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;
    localparam logic [11:0] CSR_MSTATUS = 12'h300;

    localparam int MS_MIE    = 3;
    localparam int MS_MPIE   = 7;
    localparam int MS_MPP_LO = 11;
    localparam int MS_MPP_HI = 12;

    typedef enum logic [2:0] {
        S_IDLE,
        S_T_MEPC,
        S_T_MCAUSE,
        S_T_MSTAT,
        S_T_JUMP,
        S_R_MSTAT,
        S_R_JUMP
    } state_e;

endpackage

// File: rtl/ysyx_23060191_mstatus_upd.sv
// Next-value of mstatus for trap entry (i_is_ret=0) or mret (i_is_ret=1).
// Only MIE, MPIE and MPP change; every other bit passes through.
import ysyx_23060191_trap_seq_pkg::*;

module ysyx_23060191_mstatus_upd #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] i_mstatus,
    input  logic            i_is_ret,
    output logic [XLEN-1:0] o_mstatus
);

    always_comb begin
        o_mstatus = i_mstatus;
        o_mstatus[MS_MPP_HI:MS_MPP_LO] = 2'b11;
        if (i_is_ret) begin
            o_mstatus[MS_MIE]  = i_mstatus[MS_MPIE];
            o_mstatus[MS_MPIE] = 1'b1;
        end else begin
            o_mstatus[MS_MPIE] = i_mstatus[MS_MIE];
            o_mstatus[MS_MIE]  = 1'b0;
        end
    end

endmodule

// File: rtl/ysyx_23060191_trap_seq.sv
// Trap/return sequencer and single write-port arbiter for the CSR file.
// ecall/mret become fixed CSR write sequences ending in one PC redirect.
import ysyx_23060191_trap_seq_pkg::*;

module ysyx_23060191_trap_seq #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             i_rst_n,
    input  logic             i_ecall,
    input  logic             i_mret,
    input  logic [XLEN-1:0]  i_pc,
    input  logic [XLEN-1:0]  i_ecall_NO,
    input  logic [XLEN-1:0]  i_mtvec,
    input  logic [XLEN-1:0]  i_mepc,
    input  logic [XLEN-1:0]  i_mstatus,
    input  logic             i_inst_wr_en,
    input  logic [11:0]      i_inst_waddr,
    input  logic [XLEN-1:0]  i_inst_wdata,
    output logic             o_csr_wr_en,
    output logic [11:0]      o_csr_waddr,
    output logic [XLEN-1:0]  o_csr_wdata,
    output logic             o_stall,
    output logic             o_redirect,
    output logic [XLEN-1:0]  o_redirect_pc,
    output logic [CNT_W-1:0] o_trap_cnt
);

    state_e           r_state;
    state_e           w_next;
    logic [XLEN-1:0]  r_pc;
    logic [XLEN-1:0]  r_cause;
    logic [XLEN-1:0]  r_redirect_pc;
    logic [CNT_W-1:0] r_trap_cnt;
    logic [XLEN-1:0]  w_mstat_upd;
    logic [XLEN-1:0]  w_jump_pc;
    logic             w_idle;
    logic             w_is_ret;

    assign w_idle   = (r_state == S_IDLE);
    assign w_is_ret = (r_state == S_R_MSTAT);

    ysyx_23060191_mstatus_upd #(
        .XLEN(XLEN)
    ) u_mstatus_upd (
        .i_mstatus (i_mstatus),
        .i_is_ret  (w_is_ret),
        .o_mstatus (w_mstat_upd)
    );

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pc       <= '0;
            r_cause    <= '0;
            r_trap_cnt <= '0;
        end else if (w_idle && i_ecall) begin
            r_pc       <= i_pc;
            r_cause    <= i_ecall_NO;
            r_trap_cnt <= r_trap_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_redirect_pc <= '0;
        end else if (o_redirect) begin
            r_redirect_pc <= w_jump_pc;
        end
    end

    // Direct mode only: mtvec low bits are the mode field, not address.
    assign w_jump_pc = (r_state == S_R_JUMP) ? i_mepc
                     : {i_mtvec[XLEN-1:2], 2'b00};

    assign o_redirect_pc = o_redirect ? w_jump_pc : r_redirect_pc;
    assign o_stall       = !w_idle || i_ecall || i_mret;
    assign o_trap_cnt    = r_trap_cnt;

    always_comb begin
        w_next      = r_state;
        o_csr_wr_en = 1'b0;
        o_csr_waddr = '0;
        o_csr_wdata = '0;
        o_redirect  = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (i_ecall) begin
                    w_next = S_T_MEPC;
                end else if (i_mret) begin
                    w_next = S_R_MSTAT;
                end else begin
                    o_csr_wr_en = i_inst_wr_en;
                    o_csr_waddr = i_inst_waddr;
                    o_csr_wdata = i_inst_wdata;
                end
            end
            S_T_MEPC: begin
                o_csr_wr_en = 1'b1;
                o_csr_waddr = CSR_MEPC;
                o_csr_wdata = r_pc;
                w_next      = S_T_MCAUSE;
            end
            S_T_MCAUSE: begin
                o_csr_wr_en = 1'b1;
                o_csr_waddr = CSR_MCAUSE;
                o_csr_wdata = r_cause;
                w_next      = S_T_MSTAT;
            end
            S_T_MSTAT: begin
                o_csr_wr_en = 1'b1;
                o_csr_waddr = CSR_MSTATUS;
                o_csr_wdata = w_mstat_upd;
                w_next      = S_T_JUMP;
            end
            S_T_JUMP: begin
                o_redirect = 1'b1;
                w_next     = S_IDLE;
            end
            S_R_MSTAT: begin
                o_csr_wr_en = 1'b1;
                o_csr_waddr = CSR_MSTATUS;
                o_csr_wdata = w_mstat_upd;
                w_next      = S_R_JUMP;
            end
            S_R_JUMP: begin
                o_redirect = 1'b1;
                w_next     = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_ysyx_23060191_trap_seq.sv
// Bench for the trap/return sequencer: directed table, hand sequences
// and a random run against a queue-of-pending-actions reference model.
module tb_ysyx_23060191_trap_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_ecall, i_mret;
    logic [31:0] i_pc, i_ecall_NO, i_mtvec, i_mepc, i_mstatus;
    logic        i_inst_wr_en;
    logic [11:0] i_inst_waddr;
    logic [31:0] i_inst_wdata;

    logic        o_csr_wr_en, o_stall, o_redirect;
    logic [11:0] o_csr_waddr;
    logic [31:0] o_csr_wdata, o_redirect_pc;
    logic [15:0] o_trap_cnt;

    logic        w8_wr_en, w8_stall, w8_redirect;
    logic [11:0] w8_waddr;
    logic [31:0] w8_wdata, w8_rpc;
    logic [2:0]  w8_cnt;

    always #5 clk = ~clk;

    ysyx_23060191_trap_seq #(.XLEN(32), .CNT_W(16)) dut (
        .clk(clk), .i_rst_n(rst_n),
        .i_ecall(i_ecall), .i_mret(i_mret),
        .i_pc(i_pc), .i_ecall_NO(i_ecall_NO),
        .i_mtvec(i_mtvec), .i_mepc(i_mepc), .i_mstatus(i_mstatus),
        .i_inst_wr_en(i_inst_wr_en), .i_inst_waddr(i_inst_waddr),
        .i_inst_wdata(i_inst_wdata),
        .o_csr_wr_en(o_csr_wr_en), .o_csr_waddr(o_csr_waddr),
        .o_csr_wdata(o_csr_wdata), .o_stall(o_stall),
        .o_redirect(o_redirect), .o_redirect_pc(o_redirect_pc),
        .o_trap_cnt(o_trap_cnt)
    );

    // Narrow-counter copy so counter wrap is reachable in few ecalls.
    ysyx_23060191_trap_seq #(.XLEN(32), .CNT_W(3)) dut8 (
        .clk(clk), .i_rst_n(rst_n),
        .i_ecall(i_ecall), .i_mret(i_mret),
        .i_pc(i_pc), .i_ecall_NO(i_ecall_NO),
        .i_mtvec(i_mtvec), .i_mepc(i_mepc), .i_mstatus(i_mstatus),
        .i_inst_wr_en(i_inst_wr_en), .i_inst_waddr(i_inst_waddr),
        .i_inst_wdata(i_inst_wdata),
        .o_csr_wr_en(w8_wr_en), .o_csr_waddr(w8_waddr),
        .o_csr_wdata(w8_wdata), .o_stall(w8_stall),
        .o_redirect(w8_redirect), .o_redirect_pc(w8_rpc),
        .o_trap_cnt(w8_cnt)
    );

    typedef logic [97:0] obs_t;

    typedef struct {
        bit          is_ret;
        bit          both;
        logic [31:0] pc, no, mtvec, mepc, mst, exp_st, exp_rpc;
    } vec_t;

    localparam int OP_MEPC = 0, OP_CAUSE = 1, OP_TSTAT = 2;
    localparam int OP_TJMP = 3, OP_RSTAT = 4, OP_RJMP = 5;

    int          n_vec = 0;
    int          n_bad = 0;
    int          exp_cnt = 0;
    logic [31:0] last_rpc = '0;
    logic [31:0] m_pc, m_no;
    int          q[$];
    vec_t        tbl[7];

    function automatic obs_t obs();
        return {o_stall, o_redirect, o_csr_wr_en, o_csr_waddr,
                o_csr_wdata, o_redirect_pc, o_trap_cnt, w8_cnt};
    endfunction

    function automatic obs_t mk(logic st, logic rd, logic we,
                                logic [11:0] a, logic [31:0] d,
                                logic [31:0] r);
        logic [31:0] c;
        c = exp_cnt;
        return {st, rd, we, a, d, r, c[15:0], c[2:0]};
    endfunction

    function automatic logic [31:0] trap_st(logic [31:0] m);
        logic [31:0] r;
        r = m;
        r[7] = m[3];
        r[3] = 1'b0;
        r[12:11] = 2'b11;
        return r;
    endfunction

    function automatic logic [31:0] ret_st(logic [31:0] m);
        logic [31:0] r;
        r = m;
        r[3] = m[7];
        r[7] = 1'b1;
        r[12:11] = 2'b11;
        return r;
    endfunction

    task automatic chk(string nm, obs_t act, obs_t exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: dut=%h want=%h", nm, act, exp);
        end
    endtask

    task automatic idle_in();
        i_ecall = 0; i_mret = 0;
        i_inst_wr_en = 0; i_inst_waddr = '0; i_inst_wdata = '0;
    endtask

    task automatic run_vec(input vec_t v);
        @(negedge clk);
        idle_in();
        i_ecall = !v.is_ret;
        i_mret = v.is_ret || v.both;
        i_pc = v.pc; i_ecall_NO = v.no; i_mtvec = v.mtvec;
        i_mepc = v.mepc; i_mstatus = v.mst;
        #2 chk("accept", obs(), mk(1, 0, 0, '0, '0, last_rpc));
        if (!v.is_ret) exp_cnt++;
        @(negedge clk);
        i_ecall = 0; i_mret = 0;
        if (!v.is_ret) begin
            #2 chk("w_mepc", obs(), mk(1, 0, 1, 12'h341, v.pc, last_rpc));
            @(negedge clk);
            #2 chk("w_mcause", obs(), mk(1, 0, 1, 12'h342, v.no, last_rpc));
            @(negedge clk);
        end
        #2 chk("w_mstatus", obs(), mk(1, 0, 1, 12'h300, v.exp_st, last_rpc));
        @(negedge clk);
        #2 chk("redirect", obs(), mk(1, 1, 0, '0, '0, v.exp_rpc));
        last_rpc = v.exp_rpc;
        @(negedge clk);
        #2 chk("release", obs(), mk(0, 0, 0, '0, '0, last_rpc));
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit hit");
        $fatal(1, "timeout");
    end

    initial begin
        obs_t        e;
        int          n305;
        bit          done;
        logic [31:0] stv;

        tbl[0] = '{0, 0, 32'h80000010, 32'hB, 32'h80000103, 32'h0,
                   32'h1808, 32'h1880, 32'h80000100};
        tbl[1] = '{1, 0, 32'h0, 32'h0, 32'h0, 32'h80000014,
                   32'h1880, 32'h1888, 32'h80000014};
        tbl[2] = '{0, 0, 32'h00000400, 32'h3, 32'h20000002, 32'h0,
                   32'h0, 32'h1800, 32'h20000000};
        tbl[3] = '{0, 0, 32'hFFFFFFFC, 32'h7, 32'hFFFFFFFF, 32'h0,
                   32'hFFFFFFFF, 32'hFFFFFFF7, 32'hFFFFFFFC};
        tbl[4] = '{1, 0, 32'h0, 32'h0, 32'h0, 32'h12345678,
                   32'h00000008, 32'h1880, 32'h12345678};
        tbl[5] = '{1, 0, 32'h0, 32'h0, 32'h0, 32'h00000100,
                   32'hA5A50000, 32'hA5A51880, 32'h00000100};
        tbl[6] = '{0, 1, 32'h80000200, 32'h8, 32'h80000004, 32'h0,
                   32'h1808, 32'h1880, 32'h80000004};

        idle_in();
        i_pc = '0; i_ecall_NO = '0; i_mtvec = '0;
        i_mepc = '0; i_mstatus = '0;
        rst_n = 0;
        repeat (2) @(negedge clk);
        #2 chk("reset_state", obs(), mk(0, 0, 0, '0, '0, '0));
        @(negedge clk);
        rst_n = 1;

        // Reset landing in the middle of a trap sequence.
        @(negedge clk);
        i_ecall = 1; i_pc = 32'h100; i_ecall_NO = 32'h1;
        i_mtvec = 32'h200; i_mstatus = 32'h8;
        @(negedge clk);
        i_ecall = 0;
        @(negedge clk);
        exp_cnt = 1;
        #2 chk("pre_rst_mcause", obs(), mk(1, 0, 1, 12'h342, 32'h1, '0));
        rst_n = 0;
        exp_cnt = 0;
        #1 chk("rst_mid_seq", obs(), mk(0, 0, 0, '0, '0, '0));
        @(negedge clk);
        rst_n = 1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            #2 chk("rst_no_resume", obs(), mk(0, 0, 0, '0, '0, '0));
        end

        foreach (tbl[i]) run_vec(tbl[i]);

        // EXU write: passthrough when idle, held off by a trap.
        @(negedge clk);
        idle_in();
        i_inst_wr_en = 1; i_inst_waddr = 12'h305;
        i_inst_wdata = 32'h80001000;
        #2 chk("exu_pass", obs(),
               mk(0, 0, 1, 12'h305, 32'h80001000, last_rpc));
        @(negedge clk);
        i_ecall = 1; i_pc = 32'h80000040; i_ecall_NO = 32'h2;
        i_mtvec = 32'h80000300; i_mstatus = 32'h0;
        #2 chk("exu_blocked", obs(), mk(1, 0, 0, '0, '0, last_rpc));
        exp_cnt++;
        last_rpc = 32'h80000300;
        n305 = 0;
        done = 0;
        @(negedge clk);
        i_ecall = 0;
        for (int k = 0; k < 12 && !done; k++) begin
            #2;
            if (o_csr_wr_en && o_csr_waddr == 12'h305) n305++;
            if (!o_stall) begin
                chk("exu_release", obs(),
                    mk(0, 0, 1, 12'h305, 32'h80001000, last_rpc));
                done = 1;
            end else begin
                @(negedge clk);
            end
        end
        chk("exu_done", obs_t'(done), obs_t'(1));
        chk("exu_once", obs_t'(n305), obs_t'(1));
        @(negedge clk);
        idle_in();
        #2 chk("exu_after", obs(), mk(0, 0, 0, '0, '0, last_rpc));

        // Random traffic against the action-queue model.
        for (int c = 0; c < 400 || q.size() != 0; c++) begin
            @(negedge clk);
            i_ecall = (c < 400) && ($urandom_range(0, 4) == 0);
            i_mret = (c < 400) && ($urandom_range(0, 4) == 0);
            i_pc = $urandom; i_ecall_NO = $urandom;
            i_mtvec = $urandom; i_mepc = $urandom; i_mstatus = $urandom;
            i_inst_wr_en = 1'($urandom_range(0, 1));
            i_inst_waddr = 12'($urandom); i_inst_wdata = $urandom;
            if (q.size() == 0) begin
                if (i_ecall || i_mret)
                    e = mk(1, 0, 0, '0, '0, last_rpc);
                else
                    e = mk(0, 0, i_inst_wr_en, i_inst_waddr,
                           i_inst_wdata, last_rpc);
            end else begin
                case (q[0])
                    OP_MEPC:  e = mk(1, 0, 1, 12'h341, m_pc, last_rpc);
                    OP_CAUSE: e = mk(1, 0, 1, 12'h342, m_no, last_rpc);
                    OP_TSTAT: e = mk(1, 0, 1, 12'h300,
                                     trap_st(i_mstatus), last_rpc);
                    OP_RSTAT: e = mk(1, 0, 1, 12'h300,
                                     ret_st(i_mstatus), last_rpc);
                    OP_TJMP: begin
                        stv = i_mtvec & 32'hFFFFFFFC;
                        e = mk(1, 1, 0, '0, '0, stv);
                    end
                    default: e = mk(1, 1, 0, '0, '0, i_mepc);
                endcase
            end
            #2 chk("rand", obs(), e);
            if (q.size() == 0) begin
                if (i_ecall) begin
                    m_pc = i_pc; m_no = i_ecall_NO;
                    exp_cnt++;
                    q = '{OP_MEPC, OP_CAUSE, OP_TSTAT, OP_TJMP};
                end else if (i_mret) begin
                    q = '{OP_RSTAT, OP_RJMP};
                end
            end else begin
                if (q[0] == OP_TJMP) last_rpc = i_mtvec & 32'hFFFFFFFC;
                if (q[0] == OP_RJMP) last_rpc = i_mepc;
                void'(q.pop_front());
            end
        end

        // Counter wrap on the narrow instance.
        for (int k = 0; k < 8 && exp_cnt % 8 != 7; k++) run_vec(tbl[0]);
        run_vec(tbl[0]);
        chk("cnt8_wrap", obs_t'(w8_cnt), obs_t'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
